// File: rtl/switch_rr.sv
// NPORT x NPORT crossbar with a round-robin arbiter per output and wormhole locking.
// An output stays held by one input from a packet's head flit through its tail flit.
module switch_rr #(
    parameter int DATA_W = 8,
    parameter int NPORT  = 5,
    parameter int SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NPORT*DATA_W-1:0] In,
    input  logic [NPORT*SEL_W-1:0]  request,
    input  logic [NPORT-1:0]        tail,
    input  logic [NPORT-1:0]        full,
    output logic [NPORT*DATA_W-1:0] Out,
    output logic [NPORT-1:0]        valid,
    output logic [NPORT-1:0]        grant
);

    // Handshake: input i's flit is consumed at the next rising edge exactly when
    // grant[i]=1; output o moves a flit only while full[o]=0, and valid[o] marks
    // the cycle after that transfer.

    logic [DATA_W-1:0] in_flit [NPORT];
    logic [SEL_W-1:0]  req_sel [NPORT];
    logic [NPORT-1:0]  req_mat [NPORT];

    logic [NPORT-1:0]  lock_q, lock_d;
    logic [SEL_W-1:0]  owner_q [NPORT];
    logic [SEL_W-1:0]  owner_d [NPORT];
    logic [SEL_W-1:0]  ptr_q   [NPORT];
    logic [SEL_W-1:0]  ptr_d   [NPORT];
    logic [DATA_W-1:0] out_q   [NPORT];
    logic [DATA_W-1:0] out_d   [NPORT];
    logic [NPORT-1:0]  valid_q, valid_d;

    logic [NPORT-1:0]  win_vld;
    logic [SEL_W-1:0]  win_idx [NPORT];

    for (genvar g = 0; g < NPORT; g++) begin : g_port
        assign in_flit[g]                 = In[g*DATA_W +: DATA_W];
        assign req_sel[g]                 = request[g*SEL_W +: SEL_W];
        assign Out[g*DATA_W +: DATA_W]    = out_q[g];
    end

    assign valid = valid_q;

    // req_mat[o][i]: input i targets output o; codes >= NPORT match nothing.
    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                req_mat[o][i] = (int'(req_sel[i]) == o);
            end
        end
    end

    // Arbitration: a locked output only serves its owner; otherwise scan from ptr.
    // The downward scan lets the lowest offset from ptr win by overwriting.
    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < NPORT; o++) begin
            win_vld[o] = 1'b0;
            win_idx[o] = '0;
            if (!full[o]) begin
                if (lock_q[o]) begin
                    win_vld[o] = req_mat[o][owner_q[o]];
                    win_idx[o] = owner_q[o];
                end else begin
                    for (int k = NPORT - 1; k >= 0; k--) begin
                        idx = int'(ptr_q[o]) + k;
                        if (idx >= NPORT) begin
                            idx = idx - NPORT;
                        end
                        if (req_mat[o][idx]) begin
                            win_vld[o] = 1'b1;
                            win_idx[o] = SEL_W'(idx);
                        end
                    end
                end
            end
        end
    end

    // Next-state: data capture, pointer advance on heads, lock until tail.
    always_comb begin
        lock_d  = lock_q;
        valid_d = '0;
        for (int o = 0; o < NPORT; o++) begin
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            out_d[o]   = out_q[o];
            if (win_vld[o]) begin
                out_d[o]   = in_flit[win_idx[o]];
                valid_d[o] = 1'b1;
                if (!lock_q[o]) begin
                    ptr_d[o] = (win_idx[o] == SEL_W'(NPORT - 1)) ? '0 : win_idx[o] + 1'b1;
                end
                if (tail[win_idx[o]]) begin
                    lock_d[o] = 1'b0;
                end else begin
                    lock_d[o]  = 1'b1;
                    owner_d[o] = win_idx[o];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q  <= '0;
            valid_q <= '0;
            for (int o = 0; o < NPORT; o++) begin
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
                out_q[o]   <= '0;
            end
        end else begin
            lock_q  <= lock_d;
            valid_q <= valid_d;
            for (int o = 0; o < NPORT; o++) begin
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
                out_q[o]   <= out_d[o];
            end
        end
    end

    // Each input targets at most one output, so at most one winner maps to each grant bit.
    always_comb begin
        grant = '0;
        for (int o = 0; o < NPORT; o++) begin
            if (win_vld[o]) begin
                grant[win_idx[o]] = 1'b1;
            end
        end
        if (!rst) begin
            grant = '0;
        end
    end

endmodule

// File: tb/tb_switch_rr.sv
// Directed bench for switch_rr: a table of per-cycle vectors plus a hand-written
// reset-during-packet sequence.
module tb_switch_rr;

    localparam int NR = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] In;
    logic [14:0] request;
    logic [4:0]  tail;
    logic [4:0]  full;
    logic [39:0] Out;
    logic [4:0]  valid;
    logic [4:0]  grant;

    int n_cmp = 0;
    int n_err = 0;
    logic [39:0] exp_q[$];

    typedef struct {
        logic [14:0] req;
        logic [39:0] din;
        logic [4:0]  tl;
        logic [4:0]  fl;
        logic [4:0]  eg;
        logic [4:0]  ev;
        logic [39:0] eo;
    } vec_t;

    vec_t tbl[$];

    switch_rr #(.DATA_W(8), .NPORT(5), .SEL_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .In      (In),
        .request (request),
        .tail    (tail),
        .full    (full),
        .Out     (Out),
        .valid   (valid),
        .grant   (grant)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] rq(input int r0, input int r1, input int r2,
                                       input int r3, input int r4);
        return {3'(r4), 3'(r3), 3'(r2), 3'(r1), 3'(r0)};
    endfunction

    function automatic logic [39:0] d5(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3,
                                       input logic [7:0] b4);
        return {b4, b3, b2, b1, b0};
    endfunction

    function automatic vec_t mk(input logic [14:0] rqv, input logic [39:0] d,
                                input logic [4:0] tl, input logic [4:0] fl,
                                input logic [4:0] eg, input logic [4:0] ev,
                                input logic [39:0] eo);
        vec_t v;
        v.req = rqv;
        v.din = d;
        v.tl  = tl;
        v.fl  = fl;
        v.eg  = eg;
        v.ev  = ev;
        v.eo  = eo;
        return v;
    endfunction

    task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check combinational grant, then registered outputs after the edge.
    task automatic step(input string nm, input vec_t v);
        @(negedge clk);
        request = v.req;
        In      = v.din;
        tail    = v.tl;
        full    = v.fl;
        #2;
        check({nm, " grant"}, 40'(grant), 40'(v.eg));
        exp_q.push_back(v.eo);
        @(posedge clk);
        #1;
        check({nm, " valid"}, 40'(valid), 40'(v.ev));
        check({nm, " out"}, Out, exp_q.pop_front());
    endtask

    initial begin
        // Basic single-flit transfer and idle follow-up.
        tbl.push_back(mk(rq(2,NR,NR,NR,NR), d5(8'h11,0,0,0,0), 5'b00001, 5'b0, 5'b00001, 5'b00100, d5(0,0,8'h11,0,0)));
        tbl.push_back(mk(rq(NR,NR,NR,NR,NR), '0, 5'b0, 5'b0, 5'b0, 5'b0, d5(0,0,8'h11,0,0)));
        // Inputs 1, 3, 4 contend for output 2: rotation 1, 3, 4, then 1 again.
        tbl.push_back(mk(rq(NR,2,NR,2,2), d5(0,8'h21,0,8'h23,8'h24), 5'b11010, 5'b0, 5'b00010, 5'b00100, d5(0,0,8'h21,0,0)));
        tbl.push_back(mk(rq(NR,2,NR,2,2), d5(0,8'h21,0,8'h23,8'h24), 5'b11010, 5'b0, 5'b01000, 5'b00100, d5(0,0,8'h23,0,0)));
        tbl.push_back(mk(rq(NR,2,NR,2,2), d5(0,8'h21,0,8'h23,8'h24), 5'b11010, 5'b0, 5'b10000, 5'b00100, d5(0,0,8'h24,0,0)));
        tbl.push_back(mk(rq(NR,2,NR,2,2), d5(0,8'h21,0,8'h23,8'h24), 5'b11010, 5'b0, 5'b00010, 5'b00100, d5(0,0,8'h21,0,0)));
        tbl.push_back(mk(rq(NR,NR,NR,NR,NR), '0, 5'b0, 5'b0, 5'b0, 5'b0, d5(0,0,8'h21,0,0)));
        // 3-flit packet from input 1 to output 0 locks out input 2.
        tbl.push_back(mk(rq(NR,0,0,NR,NR), d5(0,8'hA1,8'hB2,0,0), 5'b00100, 5'b0, 5'b00010, 5'b00001, d5(8'hA1,0,8'h21,0,0)));
        tbl.push_back(mk(rq(NR,0,0,NR,NR), d5(0,8'hA2,8'hB2,0,0), 5'b00100, 5'b0, 5'b00010, 5'b00001, d5(8'hA2,0,8'h21,0,0)));
        tbl.push_back(mk(rq(NR,0,0,NR,NR), d5(0,8'hA3,8'hB2,0,0), 5'b00110, 5'b0, 5'b00010, 5'b00001, d5(8'hA3,0,8'h21,0,0)));
        tbl.push_back(mk(rq(NR,NR,0,NR,NR), d5(0,0,8'hB2,0,0), 5'b00100, 5'b0, 5'b00100, 5'b00001, d5(8'hB2,0,8'h21,0,0)));
        // Locked output with an idle owner is a bubble for everyone else.
        tbl.push_back(mk(rq(NR,0,NR,NR,NR), d5(0,8'hC1,0,0,0), 5'b0, 5'b0, 5'b00010, 5'b00001, d5(8'hC1,0,8'h21,0,0)));
        tbl.push_back(mk(rq(NR,NR,0,NR,NR), d5(0,0,8'hB2,0,0), 5'b00100, 5'b0, 5'b0, 5'b0, d5(8'hC1,0,8'h21,0,0)));
        tbl.push_back(mk(rq(NR,0,0,NR,NR), d5(0,8'hC2,8'hB2,0,0), 5'b00110, 5'b0, 5'b00010, 5'b00001, d5(8'hC2,0,8'h21,0,0)));
        tbl.push_back(mk(rq(NR,NR,0,NR,NR), d5(0,0,8'hB2,0,0), 5'b00100, 5'b0, 5'b00100, 5'b00001, d5(8'hB2,0,8'h21,0,0)));
        // Backpressure on output 3, including a lock held across full.
        tbl.push_back(mk(rq(NR,NR,NR,NR,3), d5(0,0,0,0,8'h44), 5'b10000, 5'b01000, 5'b0, 5'b0, d5(8'hB2,0,8'h21,0,0)));
        tbl.push_back(mk(rq(NR,NR,NR,NR,3), d5(0,0,0,0,8'h44), 5'b10000, 5'b0, 5'b10000, 5'b01000, d5(8'hB2,0,8'h21,8'h44,0)));
        tbl.push_back(mk(rq(3,NR,NR,NR,NR), d5(8'h51,0,0,0,0), 5'b0, 5'b0, 5'b00001, 5'b01000, d5(8'hB2,0,8'h21,8'h51,0)));
        tbl.push_back(mk(rq(3,NR,3,NR,NR), d5(8'h52,0,8'h53,0,0), 5'b00101, 5'b01000, 5'b0, 5'b0, d5(8'hB2,0,8'h21,8'h51,0)));
        tbl.push_back(mk(rq(NR,NR,3,NR,NR), d5(0,0,8'h53,0,0), 5'b00100, 5'b0, 5'b0, 5'b0, d5(8'hB2,0,8'h21,8'h51,0)));
        tbl.push_back(mk(rq(3,NR,3,NR,NR), d5(8'h52,0,8'h53,0,0), 5'b00101, 5'b0, 5'b00001, 5'b01000, d5(8'hB2,0,8'h21,8'h52,0)));
        tbl.push_back(mk(rq(NR,NR,3,NR,NR), d5(0,0,8'h53,0,0), 5'b00100, 5'b0, 5'b00100, 5'b01000, d5(8'hB2,0,8'h21,8'h53,0)));
        // All five outputs in parallel, out-of-range codes, U-turn, full on one output only.
        tbl.push_back(mk(rq(1,2,3,4,0), d5(8'h60,8'h61,8'h62,8'h63,8'h64), 5'b11111, 5'b0, 5'b11111, 5'b11111, d5(8'h64,8'h60,8'h61,8'h62,8'h63)));
        tbl.push_back(mk(rq(5,6,7,5,6), d5(8'h70,8'h71,8'h72,8'h73,8'h74), 5'b11111, 5'b0, 5'b0, 5'b0, d5(8'h64,8'h60,8'h61,8'h62,8'h63)));
        tbl.push_back(mk(rq(NR,NR,NR,3,NR), d5(0,0,0,8'h77,0), 5'b01000, 5'b0, 5'b01000, 5'b01000, d5(8'h64,8'h60,8'h61,8'h77,8'h63)));
        tbl.push_back(mk(rq(1,NR,NR,NR,0), d5(8'h89,0,0,0,8'h88), 5'b10001, 5'b00001, 5'b00001, 5'b00010, d5(8'h64,8'h89,8'h61,8'h77,8'h63)));

        // Reset with a live request: outputs and grant must stay low.
        rst     = 1'b0;
        request = rq(2,NR,NR,NR,NR);
        In      = d5(8'h11,0,0,0,0);
        tail    = 5'b00001;
        full    = 5'b0;
        #12;
        check("reset grant", 40'(grant), 40'(0));
        check("reset valid", 40'(valid), 40'(0));
        check("reset out", Out, 40'(0));
        @(negedge clk);
        request = rq(NR,NR,NR,NR,NR);
        rst     = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("v%0d", i + 1), tbl[i]);
        end

        // Lock output 0 to input 1, then reset in the middle of the packet.
        step("rst_head", mk(rq(NR,0,NR,NR,NR), d5(0,8'hD1,0,0,0), 5'b0, 5'b0, 5'b00010, 5'b00001, d5(8'hD1,8'h89,8'h61,8'h77,8'h63)));
        @(negedge clk);
        request = rq(NR,0,0,NR,NR);
        In      = d5(0,8'hD2,8'hE2,0,0);
        tail    = 5'b00100;
        full    = 5'b0;
        #2;
        check("rst_body grant", 40'(grant), 40'(5'b00010));
        #1;
        rst = 1'b0;
        #1;
        check("rst_async valid", 40'(valid), 40'(0));
        check("rst_async out", Out, 40'(0));
        check("rst_async grant", 40'(grant), 40'(0));
        @(posedge clk);
        #1;
        check("rst_hold valid", 40'(valid), 40'(0));
        @(negedge clk);
        rst     = 1'b1;
        request = rq(NR,NR,0,NR,NR);
        In      = d5(0,0,8'hE2,0,0);
        tail    = 5'b00100;
        #2;
        check("rst_new grant", 40'(grant), 40'(5'b00100));
        @(posedge clk);
        #1;
        check("rst_new valid", 40'(valid), 40'(5'b00001));
        check("rst_new out", Out, d5(8'hE2,0,0,0,0));
        // Leftover body flit of the interrupted packet is arbitrated as a new head.
        step("rst_body2", mk(rq(NR,0,NR,NR,NR), d5(0,8'hD2,0,0,0), 5'b00010, 5'b0, 5'b00010, 5'b00001, d5(8'hD2,0,0,0,0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
